// File: rtl/fifo_read_ctrl_pkg.sv
// rtl/fifo_read_ctrl_pkg.sv - shared constants and helpers for the FIFO read/write controllers
// Purpose : width calculation, read-latency bounds and modular pointer arithmetic
//           shared by the read-side and write-side FIFO controllers.
// Ports   : none (package)
package fifo_read_ctrl_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Address width for a given depth; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // (ptr + inc) mod depth, valid for ptr < depth and inc <= depth, so a
    // single conditional subtraction replaces a real modulo.
    function automatic int ptr_wrap_add(input int ptr, input int inc, input int depth);
        int s;
        s = ptr + inc;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/fifo_valid_pipe.sv
// rtl/fifo_valid_pipe.sv - RD_LAT-stage delay line for the storage read-valid strobe
// Purpose : delays the read enable by the storage read latency.
// Ports   : clk, rst (async active-high), din (read enable), dout (data valid)
module fifo_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [RD_LAT-1:0] stages;

    generate
        if (RD_LAT == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[RD_LAT-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = stages[RD_LAT-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read-side controller: read pointer, occupancy, flags, read valid
// Purpose : owns the read pointer and occupancy count of a synchronous FIFO of any
//           depth, drives the storage read port and reports status to the consumer.
// Ports   : clk, rst (async active-high)
//           wr_push, read, flush          - write-side push, consumer read, discard all
//           read_addr, rd_en, rd_valid    - storage read port and delayed data valid
//           count, fifo_empty, fifo_full, almost_empty - occupancy and its decodes
//           underflow, overflow           - sticky error flags, cleared only by reset
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int AE_LEVEL = 1,
    parameter  int RD_LAT   = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_push,
    input  logic          read,
    input  logic          flush,
    output logic [AW-1:0] read_addr,
    output logic          rd_en,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          almost_empty,
    output logic          underflow,
    output logic          overflow
);

    localparam int CW = AW + 1;

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("fifo_read_ctrl: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic          push_ok;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] addr_flush;
    cnt_op_e       cnt_op;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign rd_en = read & ~fifo_empty & ~flush;

    // A push into a full FIFO still fits when a read frees a slot the same cycle.
    assign push_ok = wr_push & (~fifo_full | rd_en);

    assign addr_inc   = (read_addr == AW'(DEPTH - 1)) ? '0 : read_addr + AW'(1);
    // Flush skips the pointer past every stored entry, landing where the writer is.
    assign addr_flush = AW'(ptr_wrap_add(int'(read_addr), int'(count), DEPTH));

    always_comb begin
        cnt_op = CNT_HOLD;
        if (push_ok && !rd_en) begin
            cnt_op = CNT_INC;
        end else if (rd_en && !push_ok) begin
            cnt_op = CNT_DEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr <= '0;
            count     <= '0;
        end else if (flush) begin
            read_addr <= addr_flush;
            count     <= push_ok ? CW'(1) : '0;
        end else begin
            if (rd_en) begin
                read_addr <= addr_inc;
            end
            case (cnt_op)
                CNT_INC: count <= count + CW'(1);
                CNT_DEC: count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (read && fifo_empty && !flush) begin
                underflow <= 1'b1;
            end
            if (wr_push && fifo_full && !rd_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // In-flight reads survive a flush: the data was already fetched.
    fifo_valid_pipe #(
        .RD_LAT(RD_LAT)
    ) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_en),
        .dout (rd_valid)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - scoreboard testbench for fifo_read_ctrl
module tb_fifo_read_ctrl;
    import fifo_read_ctrl_pkg::*;

    localparam int DEPTH    = 6;
    localparam int AE_LEVEL = 2;
    localparam int RD_LAT   = 2;
    localparam int AW       = clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_push = 1'b0;
    logic          read = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] read_addr;
    logic          rd_en;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          underflow;
    logic          overflow;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    // Reference model: lifetime totals of entries pushed and entries removed
    // (read or flushed). Occupancy and read address follow from those.
    int n_push = 0;
    int n_gone = 0;
    bit m_uf = 0;
    bit m_of = 0;

    int due_q[$];

    fifo_read_ctrl #(
        .DEPTH    (DEPTH),
        .AE_LEVEL (AE_LEVEL),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_push      (wr_push),
        .read         (read),
        .flush        (flush),
        .read_addr    (read_addr),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .count        (count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each accepted read must produce exactly one rd_valid on its due cycle.
    always @(negedge clk) begin
        bit exp_v;
        while (due_q.size() > 0 && due_q[0] < edge_cnt) begin
            chk("rd_valid_missed", 0, 1);
            void'(due_q.pop_front());
        end
        exp_v = (due_q.size() > 0 && due_q[0] == edge_cnt);
        if (exp_v || rd_valid) begin
            chk("rd_valid", int'(rd_valid), int'(exp_v));
            if (exp_v) void'(due_q.pop_front());
        end
    end

    task automatic check_state(input string tag);
        int occ;
        occ = n_push - n_gone;
        chk({tag, ":read_addr"}, int'(read_addr), n_gone % DEPTH);
        chk({tag, ":count"}, int'(count), occ);
        chk({tag, ":fifo_empty"}, int'(fifo_empty), int'(occ == 0));
        chk({tag, ":fifo_full"}, int'(fifo_full), int'(occ == DEPTH));
        chk({tag, ":almost_empty"}, int'(almost_empty), int'(occ <= AE_LEVEL));
        chk({tag, ":underflow"}, int'(underflow), int'(m_uf));
        chk({tag, ":overflow"}, int'(overflow), int'(m_of));
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit p, input bit r, input bit f, input string tag);
        int  occ;
        bit  acc_r;
        bit  acc_p;
        wr_push = p;
        read    = r;
        flush   = f;
        #1;
        occ   = n_push - n_gone;
        acc_r = r && occ > 0 && !f;
        acc_p = p && (occ < DEPTH || acc_r);
        chk({tag, ":rd_en"}, int'(rd_en), int'(acc_r));
        if (acc_r) due_q.push_back(edge_cnt + RD_LAT);
        @(posedge clk);
        if (r && occ == 0 && !f) m_uf = 1;
        if (p && occ == DEPTH && !acc_r) m_of = 1;
        if (f) n_gone = n_push;
        else if (acc_r) n_gone++;
        if (acc_p) n_push++;
        #1;
        wr_push = 0;
        read    = 0;
        flush   = 0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        due_q.delete();
        n_push = 0;
        n_gone = 0;
        m_uf = 0;
        m_of = 0;
        #1;
        check_state(tag);
        chk({tag, ":rd_valid"}, int'(rd_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Fill to full, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, "fill");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, "drain");
        repeat (RD_LAT + 1) step(0, 0, 0, "idle");

        // Push and read together on empty: read rejected, underflow sticks.
        step(1, 1, 0, "empty_push_read");
        step(1, 0, 0, "push_after_uf");

        // Full: push+read keeps count, push alone overflows.
        do_reset("reset2");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, "fill2");
        step(1, 1, 0, "full_push_read");
        step(1, 0, 0, "full_push");

        // read_addr=4, count=4, then flush with push while a read is in flight.
        do_reset("reset3");
        for (int i = 0; i < 4; i++) step(1, 0, 0, "fill3");
        for (int i = 0; i < 4; i++) step(1, 1, 0, "stream");
        step(1, 1, 1, "flush");
        repeat (RD_LAT + 1) step(0, 0, 0, "post_flush");

        // Back-to-back reads through the almost_empty threshold.
        do_reset("reset4");
        for (int i = 0; i < 4; i++) step(1, 0, 0, "fill4");
        for (int i = 0; i < 5; i++) step(0, 1, 0, "b2b");

        // Randomized traffic with periodic resets mid-traffic.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) do_reset("rand_reset");
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 4, "rand");
        end

        repeat (RD_LAT + 2) step(0, 0, 0, "drain_end");
        chk("scoreboard_empty", due_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
